// File: rtl/irq_sequencer.sv
// External-interrupt entry/exit sequencer: picks a safe ID cycle to redirect fetch,
// captures the resume PC and tracks the handler. Optional post-exit holdoff: IRQ_HOLDOFF_EN.
module irq_sequencer #(
  parameter int HOLDOFF = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_req,
  input  logic             irq_en,
  input  logic             kernel_mode,
  input  logic             id_valid,
  input  logic             id_ctrl_xfer,
  input  logic             id_stall,
  input  logic [31:0]      id_pc,
  output logic             irq_take,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [31:0]      epc,
  output logic             epc_we,
  output logic             irq_pending,
  output logic             in_handler,
  output logic [CNT_W-1:0] irq_count
);

`ifdef IRQ_HOLDOFF_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HANDLER = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HANDLER = 2'd2
  } state_t;
`endif

  if (HOLDOFF < 1 || HOLDOFF > 255) begin : g_bad_holdoff
    $error("irq_sequencer: HOLDOFF must be in 1..255");
  end

  state_t           state_r, state_s;
  logic             take_s, exit_s;
  logic             kernel_q_r, kernel_seen_r, epc_we_r;
  logic [31:0]      epc_r;
  logic [CNT_W-1:0] irq_count_r;

  // Take only between ordinary user-mode instructions so no branch target or hazard flush is lost
  assign take_s = (state_r == ST_PENDING) & irq_en & ~kernel_mode & id_valid &
                  ~id_ctrl_xfer & ~id_stall & ~reset;
  // Handler is done when kernel mode was seen and the jr $26 return drops it in ID
  assign exit_s = (state_r == ST_HANDLER) & kernel_seen_r & kernel_q_r & ~kernel_mode;

`ifdef IRQ_HOLDOFF_EN
  logic [7:0] hold_cnt_r, hold_cnt_s;
`endif

  // Next-state logic
  always_comb begin
    state_s = state_r;
`ifdef IRQ_HOLDOFF_EN
    hold_cnt_s = hold_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (irq_req & irq_en) state_s = ST_PENDING;
        else                  state_s = ST_IDLE;
      end
      ST_PENDING: begin
        if (take_s) state_s = ST_HANDLER;
        else        state_s = ST_PENDING;
      end
      ST_HANDLER: begin
        if (exit_s) begin
`ifdef IRQ_HOLDOFF_EN
          state_s    = ST_HOLDOFF;
          hold_cnt_s = 8'(HOLDOFF - 1);
`else
          state_s = ST_IDLE;
`endif
        end else begin
          state_s = ST_HANDLER;
        end
      end
`ifdef IRQ_HOLDOFF_EN
      ST_HOLDOFF: begin
        if (hold_cnt_r == 8'd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s    = ST_HOLDOFF;
          hold_cnt_s = hold_cnt_r - 8'd1;
        end
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // State, handler tracking and resume-PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      kernel_q_r    <= 1'b0;
      kernel_seen_r <= 1'b0;
      epc_r         <= 32'd0;
      epc_we_r      <= 1'b0;
      irq_count_r   <= '0;
    end else begin
      state_r    <= state_s;
      kernel_q_r <= kernel_mode;
      epc_we_r   <= take_s;
      if (exit_s)                                         kernel_seen_r <= 1'b0;
      else if ((state_r == ST_HANDLER) && kernel_mode)    kernel_seen_r <= 1'b1;
      else                                                kernel_seen_r <= kernel_seen_r;
      if (take_s) begin
        epc_r       <= id_pc;
        irq_count_r <= irq_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        epc_r       <= epc_r;
        irq_count_r <= irq_count_r;
      end
    end
  end

`ifdef IRQ_HOLDOFF_EN
  // Holdoff down-counter
  always_ff @(posedge clk) begin
    if (reset) hold_cnt_r <= 8'd0;
    else       hold_cnt_r <= hold_cnt_s;
  end
`endif

  assign irq_take    = take_s;
  assign flush_ifid  = take_s;
  assign flush_idex  = take_s;
  assign epc         = epc_r;
  assign epc_we      = epc_we_r;
  assign irq_pending = (state_r == ST_PENDING);
  assign in_handler  = (state_r == ST_HANDLER);
  assign irq_count   = irq_count_r;

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Sequences external-interrupt entry and exit for the five-stage pipeline. Latches the peripheral interrupt request and picks a safe cycle to take it: ID holds a valid, non-control-transfer instruction that is not stalled, and the core is in user mode. On that cycle it redirects fetch, flushes IF/ID and ID/EX, and captures the resume PC. It then tracks the handler until the core leaves kernel mode. It sits beside the hazard and forward units and drives the irq redirect into the IF PC mux and the flush inputs of the IF/ID and ID/EX registers.

## Interface
- HOLDOFF, 4: cycles new interrupts are blocked after handler exit (1..255; only used with IRQ_HOLDOFF_EN).
- CNT_W, 16: width of the taken-interrupt counter.

- clk  in  1  core clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- irq_req  in  1  level interrupt request from the peripheral block (timer/UART).
- irq_en  in  1  global interrupt enable.
- kernel_mode  in  1  ID_PC[31].
- id_valid  in  1  ID holds a real instruction, not a bubble or flush.
- id_ctrl_xfer  in  1  ID instruction is a branch, j, jal, jr or jalr.
- id_stall  in  1  load-use stall is active this cycle.
- id_pc  in  32  PC of the instruction in ID.
- irq_take  out  1  redirect fetch to 0x80000004 this cycle.
- flush_ifid  out  1  clear IF/ID (equals irq_take).
- flush_idex  out  1  turn the ID instruction into a bubble (equals irq_take).
- epc  out  32  captured resume PC; written to $26 by ID.
- epc_we  out  1  one-cycle pulse, the cycle after irq_take.
- irq_pending  out  1  state == PENDING.
- in_handler  out  1  state == HANDLER.
- irq_count  out  CNT_W  number of interrupts taken; wraps.

## Operation
- States: IDLE, PENDING, HANDLER, HOLDOFF.
- IDLE: if irq_req & irq_en, go to PENDING.
- PENDING: the request is sticky. Dropping irq_req does not cancel it; dropping irq_en only blocks the take.
- take = PENDING & irq_en & ~kernel_mode & id_valid & ~id_ctrl_xfer & ~id_stall. It is combinational.
- take is suppressed during control transfers so that the branch target and the flush owned by the hazard unit are never lost.
- On take:
  - irq_take, flush_ifid and flush_idex are high for that cycle.
  - epc <= id_pc, because the cancelled ID instruction is re-executed on return.
  - epc_we pulses on the following cycle.
  - irq_count increments and wraps at 2^CNT_W.
  - Next state is HANDLER.
- HANDLER:
  - kernel_mode_q is kernel_mode registered.
  - kernel_seen is set once kernel_mode is 1.
  - Exit when kernel_seen & kernel_q & ~kernel_mode, i.e. the jr $26 return reached ID.
  - On exit, go to HOLDOFF (macro defined) or IDLE (macro undefined). Clear kernel_seen.
- irq_req is ignored in HANDLER; a level still high on return re-latches from IDLE.
- Simultaneous take and id_stall cannot happen, because take requires ~id_stall.

## Timing
- Reset values:
  - state IDLE, epc 0, epc_we 0, irq_count 0, kernel_q 0, kernel_seen 0, holdoff counter 0.
  - All combinational outputs are 0 in IDLE.
- Latency: irq_req high at edge N gives irq_pending in cycle N+1. Earliest irq_take is in cycle N+1.
- epc holds its value from the take edge until the next take.
- Reset asserted in any state returns to IDLE at the next edge.
  - A pending request is discarded.
  - A request still high re-latches one cycle after reset deasserts.

## Configuration
- IRQ_HOLDOFF_EN defined:
  - On handler exit, go to HOLDOFF and load the counter with HOLDOFF-1.
  - Decrement every cycle; at 0, go to IDLE.
  - irq_req is ignored throughout. This guarantees at least HOLDOFF user-mode cycles of progress between interrupts.
- IRQ_HOLDOFF_EN undefined: the HOLDOFF state and counter are absent, and HANDLER exit goes straight to IDLE.

## Test plan
- Basic take:
  - Stimulus: irq_req=1, irq_en=1, id_valid=1, id_pc=0x00000040, user mode.
  - Response: irq_take one cycle later, epc=0x00000040, epc_we the next cycle, irq_count=1.
- Branch and stall deferral:
  - Stimulus: PENDING with id_ctrl_xfer=1 for 2 cycles, then id_stall=1 for 1 cycle, then both 0 with id_pc=0x0000010C.
  - Response: irq_take only in the 4th cycle, epc=0x0000010C.
- Sticky request and enable:
  - Stimulus: irq_req pulses for 1 cycle while irq_en=0 in PENDING for 3 cycles, then irq_en=1.
  - Response: the take occurs once irq_en=1, with no loss of the request.
- Handler tracking:
  - Stimulus: after the take, kernel_mode=1 for 10 cycles with irq_req held high, then 0.
  - Response: no second take during kernel mode. The state leaves HANDLER on the falling edge.
  - Response with the macro undefined: re-take 2 cycles after exit.
  - Response with the macro defined and HOLDOFF=4: re-take no earlier than 4 cycles after exit.
- Reset mid-pending:
  - Stimulus: reset=1 for 1 cycle while PENDING.
  - Response: IDLE, irq_count=0, epc=0, no irq_take in the reset cycle.
  - Response: irq_pending returns one cycle after release if irq_req is still high.
